ysyx_24070016_mcore: RTL and testbench

Multi-cycle RV32I-subset core top. Fetches over a valid/ready instruction-memory port instead of a combinational read. Executes ADDI, ADD, LUI, AUIPC, JAL, JALR and EBREAK with a state-machine sequencer. Adds a parametrised reset vector, RV32E/RV32I register-file depth, retire and halt reporting, and illegal-instruction detection. Sits at the top of the NPC and is driven by the simulation harness, which services the memory port.

---
 rtl/ysyx_24070016_pkg.sv | 37 +++
 rtl/ysyx_24070016_mcore_if.sv | 33 +++
 rtl/ysyx_24070016_gpr.sv | 49 ++++
 rtl/ysyx_24070016_mcore.sv | 213 +++++++++++++++++++++
 tb/tb_ysyx_24070016_mcore.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_24070016_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_24070016_pkg
// Shared definitions for the multi-cycle core: RV32I opcode/funct encodings
// for the supported subset, the sequencer state enum and the register index
// width used on the register-file ports.
// ---------------------------------------------------------------------------
package ysyx_24070016_pkg;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_JALR = 3'b000;
  localparam logic [6:0] F7_ADD  = 7'b0000000;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  // Instruction register fields are always 5 bits; RV32E cores reject the
  // upper half of the index space in decode rather than narrowing the field.
  localparam int NR_REGS_DEFAULT = 32;
  localparam int REG_IDX_W       = $clog2(NR_REGS_DEFAULT);

  localparam logic [REG_IDX_W-1:0] A0_IDX = REG_IDX_W'(10);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_e;

endpackage

// File: rtl/ysyx_24070016_mcore_if.sv
// ---------------------------------------------------------------------------
// ysyx_24070016_mcore_if
// Instruction-memory port of the core: a valid/ready request channel that
// carries the fetch address and a valid-only response channel that carries
// the instruction word.
//   master : core side (drives request, receives response)
//   slave  : memory side (accepts request, drives response)
// ---------------------------------------------------------------------------
interface ysyx_24070016_mcore_if;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data
  );

endinterface

// File: rtl/ysyx_24070016_gpr.sv
// ---------------------------------------------------------------------------
// ysyx_24070016_gpr
// NR_REGS x 32 general-purpose register file.
//   clk        : write clock
//   i_we       : write enable
//   i_waddr    : write index
//   i_wdata    : write data
//   i_raddr1/2 : asynchronous read indices
//   o_rdata1/2 : read data, zero for x0 or an index beyond NR_REGS
// No reset: only x0 has a defined value.
// ---------------------------------------------------------------------------
module ysyx_24070016_gpr
  import ysyx_24070016_pkg::*;
#(
  parameter int NR_REGS = NR_REGS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [REG_IDX_W-1:0] i_waddr,
  input  logic [31:0]          i_wdata,
  input  logic [REG_IDX_W-1:0] i_raddr1,
  output logic [31:0]          o_rdata1,
  input  logic [REG_IDX_W-1:0] i_raddr2,
  output logic [31:0]          o_rdata2
);

  localparam int AW = $clog2(NR_REGS);

  logic [31:0] r_regs [NR_REGS];

  logic w_wrOk;
  logic w_rd1Ok;
  logic w_rd2Ok;

  assign w_wrOk  = (i_waddr  != '0) && (32'(i_waddr)  < 32'(NR_REGS));
  assign w_rd1Ok = (i_raddr1 != '0) && (32'(i_raddr1) < 32'(NR_REGS));
  assign w_rd2Ok = (i_raddr2 != '0) && (32'(i_raddr2) < 32'(NR_REGS));

  // Writes to x0 are dropped here so the storage slot for x0 never changes.
  always_ff @(posedge clk) begin
    if (i_we && w_wrOk) begin
      r_regs[i_waddr[AW-1:0]] <= i_wdata;
    end
  end

  assign o_rdata1 = w_rd1Ok ? r_regs[i_raddr1[AW-1:0]] : 32'd0;
  assign o_rdata2 = w_rd2Ok ? r_regs[i_raddr2[AW-1:0]] : 32'd0;

endmodule

// File: rtl/ysyx_24070016_mcore.sv
// ---------------------------------------------------------------------------
// ysyx_24070016_mcore
// Multi-cycle RV32I-subset core (ADDI, ADD, LUI, AUIPC, JAL, JALR, EBREAK).
//   clk, rst   : clock and synchronous active-high reset
//   imem       : instruction-memory port (master side)
//   pc         : current program counter
//   retire     : one-cycle pulse per committed instruction
//   halt       : sticky, core stopped
//   illegal    : sticky, stop caused by an illegal or misaligned event
//   halt_code  : x10 captured when EBREAK halts the core
// ---------------------------------------------------------------------------
module ysyx_24070016_mcore
  import ysyx_24070016_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          NR_REGS  = NR_REGS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  ysyx_24070016_mcore_if.master imem,
  output logic [31:0]           pc,
  output logic                  retire,
  output logic                  halt,
  output logic                  illegal,
  output logic [31:0]           halt_code
);

  state_e      r_state;
  state_e      w_nextState;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic        r_halt;
  logic        r_illegal;
  logic [31:0] r_haltCode;

  logic [6:0]           w_opcode;
  logic [2:0]           w_funct3;
  logic [6:0]           w_funct7;
  logic [REG_IDX_W-1:0] w_rd;
  logic [REG_IDX_W-1:0] w_rs1;
  logic [REG_IDX_W-1:0] w_rs2;
  logic [REG_IDX_W-1:0] w_raddr1;
  logic [31:0]          w_immI;
  logic [31:0]          w_immU;
  logic [31:0]          w_immJ;
  logic [31:0]          w_rs1Data;
  logic [31:0]          w_rs2Data;

  logic        w_known;
  logic        w_useRd;
  logic        w_useRs1;
  logic        w_useRs2;
  logic        w_isJump;
  logic        w_isEbreak;
  logic [31:0] w_wdata;
  logic [31:0] w_nextPc;
  logic        w_regBad;
  logic        w_illegal;
  logic        w_we;

  assign w_opcode = r_inst[6:0];
  assign w_rd     = r_inst[11:7];
  assign w_funct3 = r_inst[14:12];
  assign w_rs1    = r_inst[19:15];
  assign w_rs2    = r_inst[24:20];
  assign w_funct7 = r_inst[31:25];
  assign w_immI   = {{20{r_inst[31]}}, r_inst[31:20]};
  assign w_immU   = {r_inst[31:12], 12'b0};
  assign w_immJ   = {{12{r_inst[31]}}, r_inst[19:12], r_inst[20], r_inst[30:21], 1'b0};

  // EBREAK has no rs1 operand, so read port 1 is borrowed to fetch a0 for
  // the halt code instead of adding a third read port.
  assign w_raddr1 = (w_opcode == OP_SYSTEM) ? A0_IDX : w_rs1;

  ysyx_24070016_gpr #(
    .NR_REGS (NR_REGS)
  ) u_gpr (
    .clk      (clk),
    .i_we     (w_we),
    .i_waddr  (w_rd),
    .i_wdata  (w_wdata),
    .i_raddr1 (w_raddr1),
    .o_rdata1 (w_rs1Data),
    .i_raddr2 (w_rs2),
    .o_rdata2 (w_rs2Data)
  );

  // Decode and execute the latched instruction. Anything not explicitly
  // recognised leaves w_known low and is reported as illegal.
  always_comb begin
    w_known    = 1'b0;
    w_useRd    = 1'b0;
    w_useRs1   = 1'b0;
    w_useRs2   = 1'b0;
    w_isJump   = 1'b0;
    w_isEbreak = 1'b0;
    w_wdata    = 32'd0;
    w_nextPc   = r_pc + 32'd4;
    unique case (w_opcode)
      OP_IMM: begin
        if (w_funct3 == F3_ADD) begin
          w_known  = 1'b1;
          w_useRd  = 1'b1;
          w_useRs1 = 1'b1;
          w_wdata  = w_rs1Data + w_immI;
        end
      end
      OP_REG: begin
        if (w_funct3 == F3_ADD && w_funct7 == F7_ADD) begin
          w_known  = 1'b1;
          w_useRd  = 1'b1;
          w_useRs1 = 1'b1;
          w_useRs2 = 1'b1;
          w_wdata  = w_rs1Data + w_rs2Data;
        end
      end
      OP_LUI: begin
        w_known = 1'b1;
        w_useRd = 1'b1;
        w_wdata = w_immU;
      end
      OP_AUIPC: begin
        w_known = 1'b1;
        w_useRd = 1'b1;
        w_wdata = r_pc + w_immU;
      end
      OP_JAL: begin
        w_known  = 1'b1;
        w_useRd  = 1'b1;
        w_isJump = 1'b1;
        w_wdata  = r_pc + 32'd4;
        w_nextPc = r_pc + w_immJ;
      end
      OP_JALR: begin
        if (w_funct3 == F3_JALR) begin
          w_known  = 1'b1;
          w_useRd  = 1'b1;
          w_useRs1 = 1'b1;
          w_isJump = 1'b1;
          w_wdata  = r_pc + 32'd4;
          w_nextPc = (w_rs1Data + w_immI) & ~32'd1;
        end
      end
      OP_SYSTEM: begin
        if (r_inst == INST_EBREAK) begin
          w_known    = 1'b1;
          w_isEbreak = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  assign w_regBad = (w_useRd  && (32'(w_rd)  >= 32'(NR_REGS))) ||
                    (w_useRs1 && (32'(w_rs1) >= 32'(NR_REGS))) ||
                    (w_useRs2 && (32'(w_rs2) >= 32'(NR_REGS)));

  assign w_illegal = !w_known || w_regBad || (w_isJump && w_nextPc[1]);

  assign w_we = (r_state == EXEC) && w_useRd && !w_illegal;

  // Sequencer next state: fetch handshake, response wait, one execute
  // cycle, and an absorbing halt. Responses outside WAIT are ignored.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      FETCH: if (imem.imem_req_ready) w_nextState = WAIT;
      WAIT:  if (imem.imem_resp_valid) w_nextState = EXEC;
      EXEC:  w_nextState = (w_illegal || w_isEbreak) ? HALT : FETCH;
      HALT:  w_nextState = HALT;
      default: w_nextState = FETCH;
    endcase
  end

  // Architectural state. On a halting EXEC the pc is left pointing at the
  // offending or EBREAK instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= FETCH;
      r_pc       <= RESET_PC;
      r_halt     <= 1'b0;
      r_illegal  <= 1'b0;
      r_haltCode <= 32'd0;
    end else begin
      r_state <= w_nextState;
      if (r_state == WAIT && imem.imem_resp_valid) begin
        r_inst <= imem.imem_resp_data;
      end
      if (r_state == EXEC) begin
        if (w_illegal) begin
          r_halt    <= 1'b1;
          r_illegal <= 1'b1;
        end else if (w_isEbreak) begin
          r_halt     <= 1'b1;
          r_haltCode <= w_rs1Data;
        end else begin
          r_pc <= w_nextPc;
        end
      end
    end
  end

  assign imem.imem_req_valid = (r_state == FETCH);
  assign imem.imem_req_addr  = r_pc;

  assign pc        = r_pc;
  assign retire    = (r_state == EXEC) && !w_illegal && !w_isEbreak;
  assign halt      = r_halt;
  assign illegal   = r_illegal;
  assign halt_code = r_haltCode;

endmodule

// File: tb/tb_ysyx_24070016_mcore.sv
// ---------------------------------------------------------------------------
// tb_ysyx_24070016_mcore
// Directed programs for the multi-cycle core (RV32E build) with a memory
// model servicing the fetch port. Expected retire/halt events are queued
// before each program and consumed by a monitor as the core reports them.
// ---------------------------------------------------------------------------
module tb_ysyx_24070016_mcore;

  localparam logic [31:0] RESET_PC    = 32'h8000_0000;
  localparam int          NR_REGS     = 16;
  localparam int          MEM_WORDS   = 16;
  localparam logic [31:0] STRAY_INST  = 32'h0630_0513;

  typedef struct {
    bit          isHalt;
    logic [31:0] pc;
    logic [31:0] nextPc;
    bit          illegal;
    logic [31:0] code;
    int          cycle;
  } expect_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc;
  logic        retire;
  logic        halt;
  logic        illegal;
  logic [31:0] haltCode;

  ysyx_24070016_mcore_if bus ();

  ysyx_24070016_mcore #(
    .RESET_PC (RESET_PC),
    .NR_REGS  (NR_REGS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .imem      (bus.master),
    .pc        (pc),
    .retire    (retire),
    .halt      (halt),
    .illegal   (illegal),
    .halt_code (haltCode)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  expect_t     sb [$];
  logic [31:0] progMem [MEM_WORDS];
  int          readyDelay = 0;
  int          respDelay = 0;
  bit          strayResp = 0;
  logic [31:0] expFetchAddr = RESET_PC;

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  task automatic flagFail(string name, string detail);
    checks++;
    failures++;
    $display("[TB] FAIL %s %s", name, detail);
  endtask

  function automatic logic [31:0] memRead(logic [31:0] addr);
    logic [31:0] off;
    off = addr - RESET_PC;
    if (off[31:2] < 30'(MEM_WORDS)) return progMem[off[5:2]];
    return 32'd0;
  endfunction

  // cycle 1 is the first cycle in which the core sees reset released
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Memory model: ready after readyDelay FETCH cycles, response after
  // respDelay WAIT cycles; every presented fetch address is checked.
  bit          pending = 0;
  int          cnt = 0;
  logic [31:0] reqAddr;
  always @(negedge clk) begin
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    if (rst) begin
      pending      = 0;
      cnt          = 0;
      expFetchAddr = RESET_PC;
    end else if (strayResp) begin
      strayResp           = 0;
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = STRAY_INST;
      checkOutput("strayReqValid", {31'b0, bus.imem_req_valid}, 32'd1);
      checkOutput("strayReqAddr", bus.imem_req_addr, RESET_PC);
    end else if (pending) begin
      if (cnt >= respDelay) begin
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = memRead(reqAddr);
        pending = 0;
        cnt     = 0;
      end else begin
        cnt++;
      end
    end else if (bus.imem_req_valid) begin
      checkOutput("fetchAddr", bus.imem_req_addr, expFetchAddr);
      if (cnt >= readyDelay) begin
        bus.imem_req_ready = 1'b1;
        reqAddr = bus.imem_req_addr;
        pending = 1;
        cnt     = 0;
      end else begin
        cnt++;
      end
    end
  end

  // Monitor: every retire and the rising edge of halt consume one queued
  // expectation in order.
  bit haltSeen = 0;
  always @(negedge clk) begin
    expect_t e;
    if (rst) begin
      haltSeen = 0;
    end else begin
      if (retire) begin
        if (sb.size() == 0) begin
          flagFail("unexpectedRetire", $sformatf("actual pc=0x%08h required no retire", pc));
        end else begin
          e = sb.pop_front();
          checkOutput("retireKind", 32'd0, {31'b0, e.isHalt});
          checkOutput("retirePc", pc, e.pc);
          if (e.cycle != 0) checkOutput("retireCycle", cyc, e.cycle);
          expFetchAddr = e.nextPc;
        end
      end
      if (halt && !haltSeen) begin
        haltSeen = 1;
        if (sb.size() == 0) begin
          flagFail("unexpectedHalt", $sformatf("actual pc=0x%08h required no halt", pc));
        end else begin
          e = sb.pop_front();
          checkOutput("haltKind", 32'd1, {31'b0, e.isHalt});
          checkOutput("haltPc", pc, e.pc);
          checkOutput("haltIllegal", {31'b0, illegal}, {31'b0, e.illegal});
          checkOutput("haltCode", haltCode, e.code);
          if (e.cycle != 0) checkOutput("haltCycle", cyc, e.cycle);
        end
      end
    end
  end

  task automatic expectRetire(logic [31:0] ePc, logic [31:0] eNext, int eCycle);
    expect_t e;
    e = '{isHalt: 0, pc: ePc, nextPc: eNext, illegal: 0, code: 32'd0, cycle: eCycle};
    sb.push_back(e);
  endtask

  task automatic expectHalt(logic [31:0] ePc, bit eIllegal, logic [31:0] eCode, int eCycle);
    expect_t e;
    e = '{isHalt: 1, pc: ePc, nextPc: ePc, illegal: eIllegal, code: eCode, cycle: eCycle};
    sb.push_back(e);
  endtask

  task automatic loadProgram(input logic [31:0] words [$]);
    for (int i = 0; i < MEM_WORDS; i++) progMem[i] = 32'd0;
    for (int i = 0; i < words.size(); i++) progMem[i] = words[i];
  endtask

  task automatic checkResetState();
    checkOutput("rstPc", pc, RESET_PC);
    checkOutput("rstRetire", {31'b0, retire}, 32'd0);
    checkOutput("rstHalt", {31'b0, halt}, 32'd0);
    checkOutput("rstIllegal", {31'b0, illegal}, 32'd0);
    checkOutput("rstHaltCode", haltCode, 32'd0);
    checkOutput("rstReqValid", {31'b0, bus.imem_req_valid}, 32'd1);
  endtask

  task automatic applyReset();
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    checkResetState();
    rst = 1'b0;
  endtask

  task automatic waitHalt(string name, int budget);
    int n;
    n = 0;
    while (!halt && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (!halt) flagFail(name, $sformatf("actual halt=0 after %0d cycles required halt=1", budget));
    @(negedge clk); #1;
    checkOutput({name, "_sbEmpty"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic applyStimulus(string name, int rdyDly, int rspDly);
    readyDelay = rdyDly;
    respDelay  = rspDly;
    applyReset();
    waitHalt(name, 200);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    $display("[TB] start");

    // addi x1,x0,5; add x2,x1,x1; ebreak
    loadProgram('{32'h0050_0093, 32'h0010_8133, 32'h0010_0073});
    expectRetire(RESET_PC,        RESET_PC + 32'd4, 3);
    expectRetire(RESET_PC + 32'd4, RESET_PC + 32'd8, 6);
    expectHalt(RESET_PC + 32'd8, 1'b0, 32'd0, 10);
    applyStimulus("basic", 0, 0);
    checkOutput("basicX2", dut.u_gpr.r_regs[2], 32'd10);
    checkOutput("basicIllegal", {31'b0, illegal}, 32'd0);

    // stalled fetch: ready after 4 low cycles, response in 3rd WAIT cycle
    loadProgram('{32'h0070_0093, 32'h0010_0073});
    expectRetire(RESET_PC, RESET_PC + 32'd4, 9);
    expectHalt(RESET_PC + 32'd4, 1'b0, 32'd0, 19);
    applyStimulus("stall", 4, 2);
    checkOutput("stallX1", dut.u_gpr.r_regs[1], 32'd7);

    // lui x5,0x12345; auipc x6,1; jal x1,8; (hole); ebreak
    loadProgram('{32'h1234_52B7, 32'h0000_1317, 32'h0080_00EF, 32'h0000_0000, 32'h0010_0073});
    expectRetire(RESET_PC,         RESET_PC + 32'd4,  3);
    expectRetire(RESET_PC + 32'd4, RESET_PC + 32'd8,  6);
    expectRetire(RESET_PC + 32'd8, RESET_PC + 32'h10, 9);
    expectHalt(RESET_PC + 32'h10, 1'b0, 32'd0, 13);
    applyStimulus("upperJal", 0, 0);
    checkOutput("luiX5", dut.u_gpr.r_regs[5], 32'h1234_5000);
    checkOutput("auipcX6", dut.u_gpr.r_regs[6], 32'h8000_1004);
    checkOutput("jalX1", dut.u_gpr.r_regs[1], 32'h8000_000C);

    // addi x17,x0,1 on the 16-register build
    loadProgram('{32'h0010_0893, 32'h0010_0073});
    expectHalt(RESET_PC, 1'b1, 32'd0, 4);
    applyStimulus("badReg", 0, 0);
    checkOutput("badRegPc", pc, RESET_PC);

    // addi x1,x0,0x55; jalr x1,2(x0) -> misaligned target
    loadProgram('{32'h0550_0093, 32'h0020_00E7, 32'h0010_0073});
    expectRetire(RESET_PC, RESET_PC + 32'd4, 3);
    expectHalt(RESET_PC + 32'd4, 1'b1, 32'd0, 7);
    applyStimulus("jalrMis", 0, 0);
    checkOutput("jalrMisX1", dut.u_gpr.r_regs[1], 32'h0000_0055);

    // reset in WAIT, then a stray response in the first FETCH cycle
    loadProgram('{32'h0010_0093, 32'h0030_0513, 32'h0010_0073});
    expectRetire(RESET_PC, RESET_PC + 32'd4, 3);
    expectRetire(RESET_PC, RESET_PC + 32'd4, 4);
    expectRetire(RESET_PC + 32'd4, RESET_PC + 32'd8, 7);
    expectHalt(RESET_PC + 32'd8, 1'b0, 32'd3, 11);
    readyDelay = 0;
    respDelay  = 0;
    applyReset();
    n = 0;
    while (!retire && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    if (!retire) flagFail("abortFirstRetire", "actual retire=0 required retire=1");
    respDelay = 50;
    @(negedge clk); #1;
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    checkResetState();
    rst       = 1'b0;
    strayResp = 1;
    respDelay = 0;
    waitHalt("abort", 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
